map_request_initiator: RTL and testbench

Requester-side front end for `map_data_structure`: queues INSERT/DELETE/LOOKUP commands from upstream logic, drives them one at a time into the map's `valid_in`/`ready_out` request port, and collects each outcome. LOOKUP results come from the map's `valid_out`/`ready_in` response port. A lookup with no response inside a bounded window is reported as a miss. Every accepted command returns exactly one response upstream, in command order.

---
 rtl/map_request_initiator.sv | 174 +++++++++++++++++
 tb/tb_map_request_initiator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/map_request_initiator.sv
// Requester front end for map_data_structure: queues commands, issues them one at a time, returns one response each in order.
// Optional MAP_INIT_STATS_EN adds saturating stat_ops/stat_miss counters.
module map_request_initiator #(
  parameter int unsigned KEY_WIDTH    = 8,
  parameter int unsigned VALUE_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned RESP_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [KEY_WIDTH-1:0]   cmd_key,
  input  logic [VALUE_WIDTH-1:0] cmd_value,
  output logic                   map_valid,
  input  logic                   map_ready,
  output logic [1:0]             map_op,
  output logic [KEY_WIDTH-1:0]   map_key,
  output logic [VALUE_WIDTH-1:0] map_value,
  input  logic                   map_rvalid,
  input  logic [VALUE_WIDTH-1:0] map_rdata,
  output logic                   map_rready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_op,
  output logic                   rsp_hit,
  output logic [VALUE_WIDTH-1:0] rsp_value,
  output logic                   busy
`ifdef MAP_INIT_STATS_EN
  ,
  output logic [15:0]            stat_ops,
  output logic [15:0]            stat_miss
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = $clog2(RESP_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_LOOKUP = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, REPORT} state_t;

  state_t                 state, state_next;
  logic [1:0]             op_mem  [FIFO_DEPTH];
  logic [KEY_WIDTH-1:0]   key_mem [FIFO_DEPTH];
  logic [VALUE_WIDTH-1:0] val_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [TMR_W-1:0]       timer;
  logic [1:0]             rsp_op_q;
  logic                   rsp_hit_q;
  logic [VALUE_WIDTH-1:0] rsp_value_q;
  logic                   push, pop, rsp_hs;

  assign push   = cmd_valid && cmd_ready && (cmd_op != OP_NOP);
  assign pop    = (state == ISSUE) && map_ready;
  assign rsp_hs = (state == REPORT) && rsp_ready;

  // Queue storage needs no reset: entries are only read once counted.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]  <= cmd_op;
      key_mem[wr_ptr] <= cmd_key;
      val_mem[wr_ptr] <= cmd_value;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (count != '0) state_next = ISSUE;
      ISSUE:    if (map_ready) state_next = (op_mem[rd_ptr] == OP_LOOKUP) ? WAIT_RSP : REPORT;
      WAIT_RSP: if (map_rvalid || (timer == TMR_LAST)) state_next = REPORT;
      REPORT:   if (rsp_ready) state_next = (count != '0) ? ISSUE : IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Response registers and lookup timeout; a response on the terminal cycle beats the miss.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer       <= '0;
      rsp_op_q    <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_value_q <= '0;
    end else if (pop) begin
      timer       <= '0;
      rsp_op_q    <= op_mem[rd_ptr];
      rsp_hit_q   <= 1'b1;
      rsp_value_q <= '0;
    end else if (state == WAIT_RSP) begin
      if (map_rvalid) begin
        rsp_hit_q   <= 1'b1;
        rsp_value_q <= map_rdata;
      end else if (timer == TMR_LAST) begin
        rsp_hit_q   <= 1'b0;
        rsp_value_q <= '0;
      end else begin
        timer <= timer + TMR_W'(1);
      end
    end
  end

  always_comb begin
    cmd_ready  = (count < CNT_FULL);
    busy       = (state != IDLE) || (count != '0);
    map_valid  = 1'b0;
    map_op     = '0;
    map_key    = '0;
    map_value  = '0;
    map_rready = 1'b0;
    rsp_valid  = 1'b0;
    rsp_op     = '0;
    rsp_hit    = 1'b0;
    rsp_value  = '0;
    case (state)
      ISSUE: begin
        map_valid = 1'b1;
        map_op    = op_mem[rd_ptr];
        map_key   = key_mem[rd_ptr];
        map_value = val_mem[rd_ptr];
      end
      WAIT_RSP: map_rready = 1'b1;
      REPORT: begin
        rsp_valid = 1'b1;
        rsp_op    = rsp_op_q;
        rsp_hit   = rsp_hit_q;
        rsp_value = rsp_value_q;
      end
      default: ;
    endcase
  end

`ifdef MAP_INIT_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_ops  <= '0;
      stat_miss <= '0;
    end else if (rsp_hs) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (!rsp_hit_q && (stat_miss != 16'hFFFF)) stat_miss <= stat_miss + 16'd1;
    end
  end
`else
  logic unused_hs;
  assign unused_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_map_request_initiator.sv
// Directed bench for map_request_initiator: table of single-command transactions plus hand-written multi-cycle sequences.
module tb_map_request_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_key;
  logic [15:0] cmd_value;
  logic        map_valid;
  logic        map_ready;
  logic [1:0]  map_op;
  logic [7:0]  map_key;
  logic [15:0] map_value;
  logic        map_rvalid;
  logic [15:0] map_rdata;
  logic        map_rready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_op;
  logic        rsp_hit;
  logic [15:0] rsp_value;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  map_request_initiator #(.KEY_WIDTH(8), .VALUE_WIDTH(16), .FIFO_DEPTH(4), .RESP_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_key(cmd_key), .cmd_value(cmd_value),
    .map_valid(map_valid), .map_ready(map_ready), .map_op(map_op), .map_key(map_key), .map_value(map_value),
    .map_rvalid(map_rvalid), .map_rdata(map_rdata), .map_rready(map_rready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_hit(rsp_hit), .rsp_value(rsp_value),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  key;
    logic [15:0] value;
    int          delay;     // cycles after request handshake that map_rvalid is sampled; 0 = never
    logic [15:0] rdata;
    logic        exp_hit;
    logic [15:0] exp_value;
    int          exp_lat;   // cycles from request handshake to rsp_valid
  } vec_t;

  vec_t vecs[7];

  initial begin
    int w, lat, nreq, nrsp, bad, cyc;
    logic pushed;
    logic [7:0] keys[8];

    vecs[0] = '{2'b01, 8'h09, 16'h1234, 0, 16'h0000, 1'b1, 16'h0000, 0};
    vecs[1] = '{2'b11, 8'h09, 16'h0000, 3, 16'h1234, 1'b1, 16'h1234, 3};
    vecs[2] = '{2'b11, 8'h05, 16'h0000, 0, 16'h0000, 1'b0, 16'h0000, 8};
    vecs[3] = '{2'b10, 8'h09, 16'h0000, 0, 16'h0000, 1'b1, 16'h0000, 0};
    vecs[4] = '{2'b11, 8'h07, 16'h0000, 1, 16'hBEEF, 1'b1, 16'hBEEF, 1};
    vecs[5] = '{2'b11, 8'h03, 16'h0000, 8, 16'hA5A5, 1'b1, 16'hA5A5, 8};
    vecs[6] = '{2'b01, 8'hFF, 16'hFFFF, 0, 16'h0000, 1'b1, 16'h0000, 0};

    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_key = '0; cmd_value = '0;
    map_ready = 1'b1; map_rvalid = 1'b0; map_rdata = '0; rsp_ready = 1'b1;
    step(); step();
    chk("reset_ctrl", {cmd_ready, map_valid, map_rready, rsp_valid, busy}, 5'b10000);
    chk("reset_map_data", {map_op, map_key, map_value}, '0);
    chk("reset_rsp_data", {rsp_op, rsp_hit, rsp_value}, '0);
    reset = 1'b1;
    step();

    // Single-command transactions
    for (int i = 0; i < 7; i++) begin
      cmd_valid = 1'b1; cmd_op = vecs[i].op; cmd_key = vecs[i].key; cmd_value = vecs[i].value;
      step();
      cmd_valid = 1'b0; cmd_op = '0;
      w = 0;
      while (!map_valid && w < 20) begin step(); w++; end
      chk($sformatf("v%0d_issue_latency", i), 64'(w), 64'd1);
      chk($sformatf("v%0d_map_req", i), {map_valid, map_op, map_key}, {1'b1, vecs[i].op, vecs[i].key});
      if (vecs[i].op == 2'b01) chk($sformatf("v%0d_map_value", i), 64'(map_value), 64'(vecs[i].value));
      step();
      chk($sformatf("v%0d_map_valid_drop", i), 64'(map_valid), 64'd0);
      chk($sformatf("v%0d_map_rready", i), 64'(map_rready), 64'(vecs[i].op == 2'b11));
      lat = 0;
      while (!rsp_valid && lat < 30) begin
        if (vecs[i].delay > 0 && lat + 1 == vecs[i].delay) begin
          map_rvalid = 1'b1; map_rdata = vecs[i].rdata;
        end
        step();
        map_rvalid = 1'b0; map_rdata = '0;
        lat++;
      end
      chk($sformatf("v%0d_rsp_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d_rsp", i), {rsp_valid, rsp_op, rsp_hit, rsp_value},
          {1'b1, vecs[i].op, vecs[i].exp_hit, vecs[i].exp_value});
      step();
      chk($sformatf("v%0d_rsp_done", i), {rsp_valid, busy}, 2'b00);
    end

    // Fill the queue while the map stalls
    map_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_key = 8'(8'h10 + i); cmd_value = 16'(i);
      chk($sformatf("fill_cmd_ready_%0d", i), 64'(cmd_ready), (i < 4) ? 64'd1 : 64'd0);
      if (i < 4) step();
    end
    step(); step();
    chk("full_stall", {cmd_ready, busy, map_valid, map_key}, {1'b0, 1'b1, 1'b1, 8'h10});
    map_ready = 1'b1;
    nreq = 0; nrsp = 0; bad = 0; cyc = 0;
    while (nrsp < 5 && cyc < 100) begin
      pushed = cmd_valid && cmd_ready;
      if (map_valid && map_ready) begin
        if (nreq < 8) keys[nreq] = map_key;
        nreq++;
      end
      if (rsp_valid) begin
        nrsp++;
        if (rsp_op !== 2'b01 || rsp_hit !== 1'b1 || rsp_value !== 16'h0) bad++;
      end
      if (map_valid && rsp_valid) bad++;
      step();
      cyc++;
      if (pushed) cmd_valid = 1'b0;
    end
    chk("fill_rsp_count", 64'(nrsp), 64'd5);
    chk("fill_req_count", 64'(nreq), 64'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("fill_order_%0d", i), 64'(keys[i]), 64'(8'h10 + i));
    chk("fill_rsp_fields", 64'(bad), 64'd0);
    chk("fill_idle", 64'(busy), 64'd0);

    // Upstream backpressure holds the DELETE response and blocks the next request
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_key = 8'h42; cmd_value = '0;
    step();
    cmd_op = 2'b01; cmd_key = 8'h43; cmd_value = 16'h0055;
    step();
    cmd_valid = 1'b0; cmd_op = '0;
    w = 0;
    while (!rsp_valid && w < 20) begin step(); w++; end
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold_%0d", i), {map_valid, rsp_valid, rsp_op, rsp_hit, rsp_value},
          {1'b0, 1'b1, 2'b10, 1'b1, 16'h0});
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("hold_release", {rsp_valid, map_valid, map_op, map_key, map_value},
        {1'b0, 1'b1, 2'b01, 8'h43, 16'h0055});
    step();
    chk("hold_second_rsp", {rsp_valid, rsp_op, rsp_hit}, {1'b1, 2'b01, 1'b1});
    step();
    chk("hold_idle", 64'(busy), 64'd0);

    // NOP is consumed without a response
    chk("nop_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_key = 8'h77;
    step();
    cmd_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid || map_valid || busy) bad++;
      step();
    end
    chk("nop_no_activity", 64'(bad), 64'd0);

    // Reset during WAIT_RSP with two queued commands
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_key = 8'h01;
    step();
    cmd_op = 2'b01; cmd_key = 8'h02;
    step();
    cmd_key = 8'h03;
    step();
    cmd_valid = 1'b0; cmd_op = '0;
    chk("pre_reset_wait", {map_rready, busy, rsp_valid}, 3'b110);
    #2 reset = 1'b0;
    #1;
    chk("midreset_ctrl", {cmd_ready, map_valid, map_rready, rsp_valid, busy}, 5'b10000);
    chk("midreset_data", {map_op, map_key, map_value, rsp_op, rsp_hit, rsp_value}, '0);
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (map_valid || rsp_valid || busy) bad++;
    end
    chk("post_reset_quiet", 64'(bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
